rgbw_frame_dispenser: RTL and testbench
=======================================

RGBW_FRAME_DISPENSER -- requirements
Module: rgbw_frame_dispenser

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of 8-bit colour channels per frame (legal 1..8).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'h55, frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, maximum clk cycles between bytes inside a frame (0 = timeout disabled).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rdy  input  1  byte-ready strobe from the SPI receiver, asynchronous to clk.
REQ-007 SHALL have port rx_byte  input  8  received byte, stable from rdy rise for at least 4 clk cycles.
REQ-008 SHALL have port lint_out  output  8  committed intensity byte.
REQ-009 SHALL have port mode_out  output  8  committed mode byte.
REQ-010 SHALL have port chan_out  output  8*CHANNELS  committed channel bytes; channel k at bits [8k+7:8k].
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (state not HUNT).
REQ-012 SHALL have port frame_ok  output  1  one-cycle pulse on successful commit.
REQ-013 SHALL have port err_chk  output  1  one-cycle pulse on checksum mismatch.
REQ-014 SHALL have port err_tmo  output  1  one-cycle pulse on inter-byte timeout.
REQ-015 SHALL have port frame_cnt  output  8  count of committed frames, wraps 255 -> 0.

Function
REQ-016 SHALL synchronise rdy through two flops and detect a byte event when stage 2 is 1 and stage 3 is 0; rx_byte SHALL be sampled in that same cycle.
REQ-017 SHALL accept frames: SYNC_BYTE, LINT, MODE, CH0..CH(CHANNELS-1), CHK; payload length = CHANNELS+2.
REQ-018 SHALL implement states HUNT, RECV, CHECK.
REQ-019 In HUNT: byte == SYNC_BYTE -> RECV, index cleared, running checksum cleared; any other byte ignored, no error.
REQ-020 In RECV: byte written to shadow slot[index], checksum XOR-accumulated, index incremented; after slot CHANNELS+1 written -> CHECK.
REQ-021 In RECV a byte equal to SYNC_BYTE SHALL be treated as data (no resynchronisation).
REQ-022 In CHECK: byte == running XOR of all payload bytes -> copy all shadow slots to outputs in one cycle, pulse frame_ok, increment frame_cnt; else pulse err_chk, outputs unchanged; both -> HUNT.
REQ-023 Outputs SHALL update, and frame_ok/err_chk SHALL assert, in the clock edge following the cycle the CHK byte event is detected; outputs never show a partial frame.
REQ-024 SHALL count clk cycles since the last byte event while in RECV or CHECK; on reaching TIMEOUT_CYC -> HUNT, pulse err_tmo, shadow discarded, outputs unchanged.
REQ-025 Byte event in the same cycle the timeout expires: timeout wins, byte dropped.
REQ-026 Timeout counter SHALL saturate and not run in HUNT; TIMEOUT_CYC = 0 disables it entirely.
REQ-027 Held-high rdy SHALL produce exactly one byte event; rdy must return low for at least 2 clk cycles between bytes.
REQ-028 frame_ok, err_chk, err_tmo SHALL be mutually exclusive in any cycle.

Reset
REQ-029 reset low SHALL immediately force state HUNT, index 0, checksum 0, timeout counter 0, synchroniser flops 0, all shadow slots 0.
REQ-030 reset low SHALL immediately force lint_out, mode_out, chan_out, frame_cnt to 0 and busy, frame_ok, err_chk, err_tmo to 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; first byte after release SHALL be evaluated in HUNT.

Verification
REQ-032 CHANNELS=4: bytes 55,80,01,10,20,30,40,C1 -> one frame_ok pulse; lint_out=80, mode_out=01, chan_out=32'h40302010, frame_cnt=1.
REQ-033 Same frame with CHK=C0 -> err_chk pulse, all outputs keep prior values, frame_cnt unchanged, busy=0.
REQ-034 Bytes 12,AA,55 then valid frame -> 12 and AA ignored, no error, frame committed, frame_cnt=1.
REQ-035 TIMEOUT_CYC=50: 55,80,01 then 60 idle cycles -> err_tmo pulse at cycle 50 after last event, busy=0; following valid frame commits normally.
REQ-036 Reset pulse after byte 3 of a frame -> outputs 0, frame_cnt 0; remaining bytes ignored until next 55.
REQ-037 256 valid frames back-to-back -> frame_cnt wraps to 0, 256 frame_ok pulses, no errors.

Source files
------------

// File: rtl/rgbw_frame_dispenser.sv
// rgbw_frame_dispenser
// Receives RGBW frames byte-by-byte from an SPI receiver whose ready strobe is
// asynchronous to clk. A frame is SYNC, LINT, MODE, CH0..CHn-1, CHK, where CHK is
// the XOR of all payload bytes. Payload is collected in shadow slots and copied
// to the outputs in a single cycle only when the checksum matches, so the
// outputs never show a partially received frame.
module rgbw_frame_dispenser #(
  parameter int unsigned CHANNELS    = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rdy,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            lint_out,
  output logic [7:0]            mode_out,
  output logic [8*CHANNELS-1:0] chan_out,
  output logic                  busy,
  output logic                  frame_ok,
  output logic                  err_chk,
  output logic                  err_tmo,
  output logic [7:0]            frame_cnt
);

  // Payload slots: 0 = LINT, 1 = MODE, 2.. = channel bytes.
  localparam int unsigned SLOTS    = CHANNELS + 2;
  localparam logic [3:0]  LAST_IDX = 4'(SLOTS - 1);
  localparam logic        TMO_EN   = (TIMEOUT_CYC != 32'd0) ? 1'b1 : 1'b0;
  // Counter value in the cycle whose closing edge is the TIMEOUT_CYC-th since the last byte.
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC != 32'd0) ? 32'(TIMEOUT_CYC - 32'd1) : 32'd0;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Running frame checksum: byte-wise XOR accumulation.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    chk_fold = acc ^ data;
  endfunction

  logic        sync1_r;
  logic        sync2_r;
  logic        sync3_r;
  logic [1:0]  state_r;
  logic [3:0]  idx_r;
  logic [7:0]  chk_r;
  logic [31:0] tmo_cnt_r;
  logic [7:0]  slot_r [SLOTS];

  logic        byte_evt_s;
  logic        tmo_hit_s;
  logic [1:0]  state_nxt_s;
  logic [3:0]  idx_nxt_s;
  logic [7:0]  chk_nxt_s;
  logic        slot_we_s;
  logic        commit_s;
  logic        bad_chk_s;
  logic        tmo_s;

  // Rising edge of the synchronised strobe; a held-high rdy yields one event.
  assign byte_evt_s = sync2_r & ~sync3_r;
  assign tmo_hit_s  = TMO_EN && (state_r != ST_HUNT) && (tmo_cnt_r == TMO_LAST);

  // Two-flop synchroniser on rdy plus a third stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= rdy;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Frame parser next-state logic; an expiring timeout takes priority over a byte.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    chk_nxt_s   = chk_r;
    slot_we_s   = 1'b0;
    commit_s    = 1'b0;
    bad_chk_s   = 1'b0;
    tmo_s       = 1'b0;
    if (tmo_hit_s) begin
      state_nxt_s = ST_HUNT;
      tmo_s       = 1'b1;
    end else if (byte_evt_s) begin
      case (state_r)
        ST_HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            state_nxt_s = ST_RECV;
            idx_nxt_s   = 4'd0;
            chk_nxt_s   = 8'd0;
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end
        ST_RECV: begin
          slot_we_s = 1'b1;
          chk_nxt_s = chk_fold(chk_r, rx_byte);
          idx_nxt_s = idx_r + 4'd1;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_RECV;
          end
        end
        ST_CHECK: begin
          state_nxt_s = ST_HUNT;
          if (rx_byte == chk_r) begin
            commit_s = 1'b1;
          end else begin
            bad_chk_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Parser state, slot index, running checksum and shadow slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_HUNT;
      idx_r   <= 4'd0;
      chk_r   <= 8'd0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        slot_r[i] <= 8'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      chk_r   <= chk_nxt_s;
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (slot_we_s && (idx_r == 4'(i))) begin
          slot_r[i] <= rx_byte;
        end
      end
    end
  end

  // Cycles since the last byte event inside a frame; idle and saturating in HUNT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= 32'd0;
    end else if (!TMO_EN || (state_r == ST_HUNT) || byte_evt_s || tmo_hit_s) begin
      tmo_cnt_r <= 32'd0;
    end else if (tmo_cnt_r != TMO_LAST) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Registered outputs: atomic commit of the shadow slots plus status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lint_out  <= 8'd0;
      mode_out  <= 8'd0;
      chan_out  <= '0;
      frame_cnt <= 8'd0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      err_chk   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      busy     <= (state_nxt_s != ST_HUNT);
      frame_ok <= commit_s;
      err_chk  <= bad_chk_s;
      err_tmo  <= tmo_s;
      if (commit_s) begin
        lint_out  <= slot_r[0];
        mode_out  <= slot_r[1];
        for (int k = 0; k < int'(CHANNELS); k++) begin
          chan_out[8*k +: 8] <= slot_r[k+2];
        end
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgbw_frame_dispenser.sv
// Testbench for rgbw_frame_dispenser: directed frame scenarios plus randomized
// frame streams checked against a byte-list reference model.
module tb_rgbw_frame_dispenser;

  localparam int CH  = 4;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic            rdy;
  logic [7:0]      rx_byte;
  logic [7:0]      lint_out;
  logic [7:0]      mode_out;
  logic [8*CH-1:0] chan_out;
  logic            busy;
  logic            frame_ok;
  logic            err_chk;
  logic            err_tmo;
  logic [7:0]      frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse tallies gathered by the monitor.
  int   ok_seen    = 0;
  int   chk_seen   = 0;
  int   tmo_seen   = 0;
  logic excl_viol  = 1'b0;

  // Reference model: collected payload bytes and expected committed state.
  bit              m_in;
  logic [7:0]      m_pay[$];
  logic [7:0]      exp_lint;
  logic [7:0]      exp_mode;
  logic [8*CH-1:0] exp_chan;
  logic [7:0]      exp_cnt;
  int              exp_ok  = 0;
  int              exp_chk = 0;
  int              exp_tmo = 0;

  rgbw_frame_dispenser #(
    .CHANNELS   (CH),
    .SYNC_BYTE  (8'h55),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rdy      (rdy),
    .rx_byte  (rx_byte),
    .lint_out (lint_out),
    .mode_out (mode_out),
    .chan_out (chan_out),
    .busy     (busy),
    .frame_ok (frame_ok),
    .err_chk  (err_chk),
    .err_tmo  (err_tmo),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Count status pulses and note any cycle with more than one asserted.
  always @(negedge clk) begin
    if (frame_ok === 1'b1) ok_seen <= ok_seen + 1;
    if (err_chk === 1'b1) chk_seen <= chk_seen + 1;
    if (err_tmo === 1'b1) tmo_seen <= tmo_seen + 1;
    if ((int'(frame_ok) + int'(err_chk) + int'(err_tmo)) > 1) excl_viol <= 1'b1;
  end

  task automatic m_reset();
    m_in = 1'b0;
    m_pay.delete();
    exp_lint = 8'd0;
    exp_mode = 8'd0;
    exp_chan = '0;
    exp_cnt  = 8'd0;
  endtask

  // Frame rules at byte level: hunt for sync, gather CH+2 bytes, then judge CHK.
  task automatic m_byte(input logic [7:0] b);
    logic [7:0] x;
    if (!m_in) begin
      if (b == 8'h55) begin
        m_in = 1'b1;
        m_pay.delete();
      end
    end else if (m_pay.size() < CH + 2) begin
      m_pay.push_back(b);
    end else begin
      x = 8'd0;
      foreach (m_pay[i]) x = x ^ m_pay[i];
      if (x == b) begin
        exp_lint = m_pay[0];
        exp_mode = m_pay[1];
        for (int k = 0; k < CH; k++) exp_chan[8*k +: 8] = m_pay[k+2];
        exp_cnt = exp_cnt + 8'd1;
        exp_ok++;
      end else begin
        exp_chk++;
      end
      m_in = 1'b0;
    end
  endtask

  task automatic m_timeout();
    m_in = 1'b0;
    m_pay.delete();
    exp_tmo++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rdy = 1'b1;
    rx_byte = b;
    repeat (5) @(negedge clk);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    m_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] m,
                            input logic [8*CH-1:0] ch, input bit corrupt);
    logic [7:0] x;
    x = l ^ m;
    for (int k = 0; k < CH; k++) x = x ^ ch[8*k +: 8];
    send_byte(8'h55);
    send_byte(l);
    send_byte(m);
    for (int k = 0; k < CH; k++) send_byte(ch[8*k +: 8]);
    send_byte(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rdy = 1'b0;
    rx_byte = 8'd0;
    m_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt} !== {(8*CH+24){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {lint_out, mode_out, chan_out, frame_cnt});
    end
    n_cmp++;
    if ({busy, frame_ok, err_chk, err_tmo} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, frame_ok, err_chk, err_tmo});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_valid_frame();
    int first;
    logic [7:0] lint_mid;
    first = 0;
    lint_mid = 8'hxx;
    send_byte(8'h55); send_byte(8'h80); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    @(negedge clk);
    rdy = 1'b1;
    rx_byte = 8'hC1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) rdy = 1'b0;
      if (k == 2) lint_mid = lint_out;
      if (frame_ok === 1'b1 && first == 0) first = k;
    end
    m_byte(8'hC1);
    n_cmp++;
    if (lint_mid !== 8'h00) begin
      n_fail++;
      $display("FAIL early_commit: lint_out before commit edge got %h expected 00", lint_mid);
    end
    n_cmp++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL commit_latency: frame_ok seen at cycle %0d expected 3", first);
    end
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt} !== {8'h80, 8'h01, 32'h40302010, 8'd1}) begin
      n_fail++;
      $display("FAIL valid_frame: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt},
               {8'h80, 8'h01, 32'h40302010, 8'd1});
    end
    n_cmp++;
    if ({ok_seen, chk_seen, tmo_seen} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL valid_pulses: ok/chk/tmo got %0d/%0d/%0d expected 1/0/0", ok_seen, chk_seen, tmo_seen);
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'h11, 8'h22, 32'h66554433, 1'b1);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt, busy} !== {8'h80, 8'h01, 32'h40302010, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_chk_hold: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt, busy},
               {8'h80, 8'h01, 32'h40302010, 8'd1, 1'b0});
    end
    n_cmp++;
    if ({ok_seen, chk_seen, tmo_seen} !== {exp_ok, exp_chk, exp_tmo}) begin
      n_fail++;
      $display("FAIL bad_chk_pulses: ok/chk/tmo got %0d/%0d/%0d expected %0d/%0d/%0d",
               ok_seen, chk_seen, tmo_seen, exp_ok, exp_chk, exp_tmo);
    end
  endtask

  task automatic test_hunt_ignore();
    send_byte(8'h12);
    send_byte(8'hAA);
    n_cmp++;
    if ({busy, chk_seen, tmo_seen} !== {1'b0, exp_chk, exp_tmo}) begin
      n_fail++;
      $display("FAIL hunt_ignore: busy/chk/tmo got %b/%0d/%0d expected 0/%0d/%0d",
               busy, chk_seen, tmo_seen, exp_chk, exp_tmo);
    end
    send_frame(8'($urandom), 8'($urandom), 32'($urandom), 1'b0);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt, busy} !== {exp_lint, exp_mode, exp_chan, exp_cnt, m_in}) begin
      n_fail++;
      $display("FAIL hunt_then_frame: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt, busy},
               {exp_lint, exp_mode, exp_chan, exp_cnt, m_in});
    end
  endtask

  task automatic test_sync_as_data();
    send_frame(8'h55, 8'h55, 32'h55555555, 1'b0);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt} !== {8'h55, 8'h55, 32'h55555555, exp_cnt}) begin
      n_fail++;
      $display("FAIL sync_as_data: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt},
               {8'h55, 8'h55, 32'h55555555, exp_cnt});
    end
    n_cmp++;
    if ({ok_seen, chk_seen, tmo_seen} !== {exp_ok, exp_chk, exp_tmo}) begin
      n_fail++;
      $display("FAIL sync_as_data_pulses: ok/chk/tmo got %0d/%0d/%0d expected %0d/%0d/%0d",
               ok_seen, chk_seen, tmo_seen, exp_ok, exp_chk, exp_tmo);
    end
  endtask

  task automatic test_timeout();
    int first;
    first = 0;
    send_byte(8'h55);
    send_byte(8'h80);
    @(negedge clk);
    rdy = 1'b1;
    rx_byte = 8'h01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) rdy = 1'b0;
      if (err_tmo === 1'b1 && first == 0) first = k;
    end
    m_byte(8'h01);
    m_timeout();
    n_cmp++;
    if (first != TMO + 3) begin
      n_fail++;
      $display("FAIL timeout_cycle: err_tmo seen at cycle %0d expected %0d", first, TMO + 3);
    end
    n_cmp++;
    if ({busy, ok_seen, chk_seen, tmo_seen} !== {1'b0, exp_ok, exp_chk, exp_tmo}) begin
      n_fail++;
      $display("FAIL timeout_state: busy/ok/chk/tmo got %b/%0d/%0d/%0d expected 0/%0d/%0d/%0d",
               busy, ok_seen, chk_seen, tmo_seen, exp_ok, exp_chk, exp_tmo);
    end
    send_frame(8'hA1, 8'hB2, 32'hC3D4E5F6, 1'b0);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt, busy} !== {exp_lint, exp_mode, exp_chan, exp_cnt, m_in}) begin
      n_fail++;
      $display("FAIL after_timeout_frame: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt, busy},
               {exp_lint, exp_mode, exp_chan, exp_cnt, m_in});
    end
  endtask

  task automatic test_timeout_race();
    int first;
    first = 0;
    @(negedge clk);
    rdy = 1'b1;
    rx_byte = 8'h55;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (k == 5) rdy = 1'b0;
      if (k == TMO) begin
        rdy = 1'b1;
        rx_byte = 8'h55;
      end
      if (k == TMO + 5) rdy = 1'b0;
      if (err_tmo === 1'b1 && first == 0) first = k;
    end
    m_byte(8'h55);
    m_timeout();
    n_cmp++;
    if (first != TMO + 3) begin
      n_fail++;
      $display("FAIL race_timeout: err_tmo seen at cycle %0d expected %0d", first, TMO + 3);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL race_byte_dropped: busy got %b expected 0", busy);
    end
    send_frame(8'h0F, 8'hF0, 32'h01020304, 1'b0);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt, ok_seen, tmo_seen} !==
        {exp_lint, exp_mode, exp_chan, exp_cnt, exp_ok, exp_tmo}) begin
      n_fail++;
      $display("FAIL after_race_frame: got %h/%0d/%0d expected %h/%0d/%0d",
               {lint_out, mode_out, chan_out, frame_cnt}, ok_seen, tmo_seen,
               {exp_lint, exp_mode, exp_chan, exp_cnt}, exp_ok, exp_tmo);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h55);
    send_byte(8'h80);
    send_byte(8'h01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt, busy} !== {(8*CH+25){1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", {lint_out, mode_out, chan_out, frame_cnt, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40); send_byte(8'hC1);
    n_cmp++;
    if ({busy, frame_cnt, ok_seen, chk_seen, tmo_seen} !== {1'b0, 8'd0, exp_ok, exp_chk, exp_tmo}) begin
      n_fail++;
      $display("FAIL post_reset_ignore: busy/cnt/ok/chk/tmo got %b/%0d/%0d/%0d/%0d expected 0/0/%0d/%0d/%0d",
               busy, frame_cnt, ok_seen, chk_seen, tmo_seen, exp_ok, exp_chk, exp_tmo);
    end
    send_frame(8'h5A, 8'hA5, 32'h11223344, 1'b0);
    n_cmp++;
    if ({lint_out, mode_out, chan_out, frame_cnt} !== {8'h5A, 8'hA5, 32'h11223344, 8'd1}) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %h expected %h", {lint_out, mode_out, chan_out, frame_cnt},
               {8'h5A, 8'hA5, 32'h11223344, 8'd1});
    end
  endtask

  task automatic test_random_mix();
    logic [7:0] junk;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h55) junk = 8'h56;
        send_byte(junk);
      end
      send_frame(8'($urandom), 8'($urandom), 32'($urandom), ($urandom_range(0, 3) == 0));
      n_cmp++;
      if ({lint_out, mode_out, chan_out, frame_cnt, busy, ok_seen, chk_seen, tmo_seen} !==
          {exp_lint, exp_mode, exp_chan, exp_cnt, m_in, exp_ok, exp_chk, exp_tmo}) begin
        n_fail++;
        $display("FAIL random_frame_%0d: got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d", f,
                 {lint_out, mode_out, chan_out, frame_cnt, busy}, ok_seen, chk_seen, tmo_seen,
                 {exp_lint, exp_mode, exp_chan, exp_cnt, m_in}, exp_ok, exp_chk, exp_tmo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ok0;
    int err0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    ok0  = ok_seen;
    err0 = chk_seen + tmo_seen;
    for (int f = 0; f < 256; f++) begin
      send_frame(8'($urandom), 8'($urandom), 32'($urandom), 1'b0);
      n_cmp++;
      if ({lint_out, mode_out, chan_out, frame_cnt} !== {exp_lint, exp_mode, exp_chan, exp_cnt}) begin
        n_fail++;
        $display("FAIL b2b_frame_%0d: got %h expected %h", f, {lint_out, mode_out, chan_out, frame_cnt},
                 {exp_lint, exp_mode, exp_chan, exp_cnt});
      end
    end
    n_cmp++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: frame_cnt got %0d expected 0", frame_cnt);
    end
    n_cmp++;
    if ({ok_seen - ok0, chk_seen + tmo_seen - err0} !== {32'd256, 32'd0}) begin
      n_fail++;
      $display("FAIL b2b_pulses: ok/err got %0d/%0d expected 256/0", ok_seen - ok0, chk_seen + tmo_seen - err0);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (excl_viol !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_exclusive: overlap flag got %b expected 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_hunt_ignore();
    test_sync_as_data();
    test_timeout();
    test_timeout_race();
    test_reset_mid_frame();
    test_random_mix();
    test_back_to_back();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
